// File: rtl/mouse_pos_ctl.sv
// mouse_pos_ctl: frame-synchronous cursor position controller.
// Raw mouse samples arrive on a valid/ready handshake and are clamped to
// the visible area. The newest sample is held as pending and is copied to
// xpos/ypos only at the start of vertical blanking, so the cursor never
// tears mid-frame.
// Optional build macro MOUSE_MARKERS_EN: when defined, left-button clicks
// capture the committed x into two alternating measurement markers (A, B).
// When undefined, the marker outputs are tied to zero and left_btn is ignored.

module mouse_pos_ctl #(
    parameter logic [11:0] XMAX = 12'd1023,
    parameter logic [11:0] YMAX = 12'd767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        left_btn,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        frame_upd,
    output logic [11:0] marker_a_x,
    output logic [11:0] marker_b_x,
    output logic [1:0]  marker_vld
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        vblnk_q;
    logic        vb_rise;
    logic        accept;
    logic [11:0] pend_x;
    logic [11:0] pend_y;

    // The only cycle a sample cannot be taken is the one-cycle commit.
    assign in_ready = (state != COMMIT);
    assign accept   = in_valid & in_ready;
    assign vb_rise  = vblnk & ~vblnk_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; a blank rise only matters if a sample is waiting.
    // NOTE: the default assignment first keeps this block free of latches on
    // any path the case statement does not cover.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = PENDING;
            PENDING: if (vb_rise) state_nxt = COMMIT;
            COMMIT:               state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Pending sample: clamped at acceptance, newest sample always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x <= '0;
            pend_y <= '0;
        end else if (accept) begin
            pend_x <= (xpos_in > XMAX) ? XMAX : xpos_in;
            pend_y <= (ypos_in > YMAX) ? YMAX : ypos_in;
        end
    end

    // Delayed vblnk for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vblnk_q <= 1'b0;
        else        vblnk_q <= vblnk;
    end

    // Committed position and its one-cycle update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos      <= '0;
            ypos      <= '0;
            frame_upd <= 1'b0;
        end else begin
            frame_upd <= (state == COMMIT);
            if (state == COMMIT) begin
                xpos <= pend_x;
                ypos <= pend_y;
            end
        end
    end

`ifdef MOUSE_MARKERS_EN
    logic btn_q;
    logic click_q;
    logic sel;

    // Button edge detect; the click is registered so markers update on the
    // edge after the one that first samples the button high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 1'b0;
            click_q <= 1'b0;
        end else begin
            btn_q   <= left_btn;
            click_q <= left_btn & ~btn_q;
        end
    end

    // Alternating marker capture of the registered (pre-commit) xpos.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            marker_a_x <= '0;
            marker_b_x <= '0;
            marker_vld <= 2'b00;
        end else if (click_q) begin
            sel <= ~sel;
            if (!sel) begin
                marker_a_x    <= xpos;
                marker_vld[0] <= 1'b1;
            end else begin
                marker_b_x    <= xpos;
                marker_vld[1] <= 1'b1;
            end
        end
    end
`else
    logic unused_left_btn;

    assign unused_left_btn = left_btn;
    assign marker_a_x      = '0;
    assign marker_b_x      = '0;
    assign marker_vld      = 2'b00;
`endif

endmodule
